// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared constants and types for the word-interleaved banked main memory.
//   - Address layout: addr[0] byte offset, addr[2:1] bank select,
//     addr[ADDR_W-1:3] row within the bank.
//   - word_t / bank_idx_t / row_t give every file the same widths.
//   - rd_slot_t is one stage of the read-return pipeline.
// No ports (package).
// -----------------------------------------------------------------------------
package mem_pkg;

    localparam int ADDR_W         = 16;
    localparam int DATA_W         = 16;
    localparam int NUM_BANKS      = 4;
    localparam int BANK_SEL_LSB   = 1;
    localparam int BANK_SEL_MSB   = 2;
    localparam int ROW_LSB        = BANK_SEL_MSB + 1;
    localparam int ROW_W          = ADDR_W - ROW_LSB;
    localparam int WORDS_PER_BANK = 8192;
    localparam int BANK_BUSY_DEF  = 4;
    localparam int RD_LAT_DEF     = 2;

    typedef logic [1:0]        bank_idx_t;
    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ROW_W-1:0]  row_t;

    typedef struct packed {
        logic  valid;
        word_t data;
    } rd_slot_t;

    // A request is illegal when it asks for both directions at once, or when
    // it targets an odd byte address (only whole words are transferred).
    function automatic logic req_err(input logic wr, input logic rd, input logic byte_lsb);
        return (wr & rd) | ((wr | rd) & byte_lsb);
    endfunction

endpackage : mem_pkg

// File: rtl/banked_mem_if.sv
// -----------------------------------------------------------------------------
// banked_mem_if
// Request/response bundle between the cache controller (master) and the
// banked memory (slave).
//   master drives : addr, data_in, wr, rd
//   slave drives  : data_out, rd_valid, stall, busy, err
// stall and err are combinational responses to the request in the same cycle;
// everything else returned by the slave is registered.
// -----------------------------------------------------------------------------
interface banked_mem_if;
    import mem_pkg::*;

    logic [ADDR_W-1:0]    addr;
    word_t                data_in;
    logic                 wr;
    logic                 rd;
    word_t                data_out;
    logic                 rd_valid;
    logic                 stall;
    logic [NUM_BANKS-1:0] busy;
    logic                 err;

    modport master (
        output addr, data_in, wr, rd,
        input  data_out, rd_valid, stall, busy, err
    );

    modport slave (
        input  addr, data_in, wr, rd,
        output data_out, rd_valid, stall, busy, err
    );

endinterface : banked_mem_if

// File: rtl/mem_bank.sv
// -----------------------------------------------------------------------------
// mem_bank
// One single-ported memory bank: storage array, occupancy down-counter and a
// registered busy flag.
//   clk, rst_n : clock, async active-low reset (counter/busy only; storage is
//                never cleared so data written before a reset survives it)
//   acc_i      : access accepted for this bank this cycle
//   wr_i       : the accepted access is a write
//   row_i      : row within the bank
//   wdata_i    : write data
//   rdata_o    : storage word at row_i (sampled by the top on a read accept)
//   busy_o     : bank occupied; high for BANK_BUSY-1 cycles after an accept
// -----------------------------------------------------------------------------
module mem_bank
    import mem_pkg::*;
#(
    parameter int BANK_BUSY = BANK_BUSY_DEF
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  acc_i,
    input  logic  wr_i,
    input  row_t  row_i,
    input  word_t wdata_i,
    output word_t rdata_o,
    output logic  busy_o
);

    localparam int CNT_W = (BANK_BUSY > 2) ? $clog2(BANK_BUSY) : 1;

    word_t            mem_q [WORDS_PER_BANK];
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             busy_q;
    logic             busy_d;

    // Occupancy next-state: load on accept, then count down to idle. busy is
    // precomputed so it is a flop output that drops exactly when the counter
    // reaches zero.
    always_comb begin
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (acc_i) begin
            cnt_d  = CNT_W'(BANK_BUSY - 1);
            busy_d = (BANK_BUSY > 1);
        end else if (cnt_q != '0) begin
            cnt_d  = cnt_q - CNT_W'(1);
            busy_d = (cnt_q > CNT_W'(1));
        end else begin
            cnt_d  = '0;
            busy_d = 1'b0;
        end
    end

    // Occupancy state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    // Storage write port; deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (acc_i && wr_i) begin
            mem_q[row_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[row_i];
    assign busy_o  = busy_q;

endmodule : mem_bank

// File: rtl/banked_mem.sv
// -----------------------------------------------------------------------------
// banked_mem
// Four-bank word-interleaved main memory behind the cache controller.
//   clk   : clock, all state on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : banked_mem_if.slave
//           addr/data_in/wr/rd in; data_out/rd_valid/busy registered out;
//           stall/err combinational out.
// Accesses to different banks pipeline one per cycle; a same-bank access
// stalls until the bank counter expires. Read data returns RD_LAT cycles after
// accept as a one-cycle rd_valid pulse, in issue order.
// -----------------------------------------------------------------------------
module banked_mem
    import mem_pkg::*;
#(
    parameter int BANK_BUSY = BANK_BUSY_DEF,
    parameter int RD_LAT    = RD_LAT_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    banked_mem_if.slave  bus
);

    logic                 req_s;
    logic                 err_s;
    logic                 stall_s;
    logic                 acc_s;
    bank_idx_t            bank_sel_s;
    row_t                 row_s;
    logic [NUM_BANKS-1:0] bank_acc_s;
    logic [NUM_BANKS-1:0] bank_busy_s;
    word_t                bank_rdata_s [NUM_BANKS];
    word_t                sel_rdata_s;
    rd_slot_t             pipe_q [RD_LAT];
    rd_slot_t             pipe_d [RD_LAT];

    // Request decode: illegal requests are neither accepted nor stalled.
    always_comb begin
        req_s       = bus.wr | bus.rd;
        err_s       = req_err(bus.wr, bus.rd, bus.addr[0]);
        bank_sel_s  = bus.addr[BANK_SEL_MSB:BANK_SEL_LSB];
        row_s       = bus.addr[ADDR_W-1:ROW_LSB];
        stall_s     = req_s & ~err_s & bank_busy_s[bank_sel_s];
        acc_s       = req_s & ~err_s & ~stall_s;
        sel_rdata_s = bank_rdata_s[bank_sel_s];
        bank_acc_s  = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            bank_acc_s[i] = acc_s && (bank_sel_s == bank_idx_t'(i));
        end
    end

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        mem_bank #(
            .BANK_BUSY (BANK_BUSY)
        ) u_bank (
            .clk     (clk),
            .rst_n   (rst_n),
            .acc_i   (bank_acc_s[g]),
            .wr_i    (bus.wr),
            .row_i   (row_s),
            .wdata_i (bus.data_in),
            .rdata_o (bank_rdata_s[g]),
            .busy_o  (bank_busy_s[g])
        );
    end

    // Read-return pipeline next state. Empty slots carry zero data so the
    // output stage drives data_out=0 whenever rd_valid=0 without extra gating.
    always_comb begin
        if (acc_s && bus.rd) begin
            pipe_d[0].valid = 1'b1;
            pipe_d[0].data  = sel_rdata_s;
        end else begin
            pipe_d[0].valid = 1'b0;
            pipe_d[0].data  = '0;
        end
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // Read-return pipeline registers; reset discards in-flight reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    assign bus.data_out = pipe_q[RD_LAT-1].data;
    assign bus.rd_valid = pipe_q[RD_LAT-1].valid;
    assign bus.busy     = bank_busy_s;
    assign bus.stall    = stall_s;
    assign bus.err      = err_s;

endmodule : banked_mem

// File: tb/tb_banked_mem.sv
// -----------------------------------------------------------------------------
// tb_banked_mem
// Directed and randomized stimulus for banked_mem, checked every cycle against
// a reference model: a word-addressed associative memory, a per-bank
// "free from cycle" table and a queue of expected read returns.
// -----------------------------------------------------------------------------
module tb_banked_mem;
    import mem_pkg::*;

    localparam int BANK_BUSY = 4;
    localparam int RD_LAT    = 2;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    banked_mem_if bus ();

    banked_mem #(
        .BANK_BUSY (BANK_BUSY),
        .RD_LAT    (RD_LAT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int          due;
        logic [15:0] data;
    } exp_rd_t;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;
    logic [15:0] model_mem [int];
    int          bank_free [4];
    exp_rd_t     exp_q [$];
    logic        last_stall;
    int          stalls;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    // One clock cycle: drive request just after the rising edge, compare all
    // outputs at the falling edge, then advance the model.
    task automatic step(input logic [15:0] a, input logic [15:0] d, input logic w, input logic r);
        logic        req;
        logic        e;
        logic        s;
        logic        ev;
        logic [15:0] ed;
        logic [3:0]  eb;
        int          b;
        int          k;
        bus.addr    = a;
        bus.data_in = d;
        bus.wr      = w;
        bus.rd      = r;
        @(negedge clk);
        req = w | r;
        e   = (w & r) | (req & a[0]);
        b   = int'(a[2:1]);
        k   = int'(a[15:1]);
        s   = req & ~e & (cyc < bank_free[b]);
        for (int i = 0; i < 4; i++) eb[i] = (cyc < bank_free[i]);
        ev = 1'b0;
        ed = 16'h0000;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            ev = 1'b1;
            ed = exp_q[0].data;
            void'(exp_q.pop_front());
        end
        check("err",      32'(bus.err),      32'(e));
        check("stall",    32'(bus.stall),    32'(s));
        check("busy",     32'(bus.busy),     32'(eb));
        check("rd_valid", 32'(bus.rd_valid), 32'(ev));
        check("data_out", 32'(bus.data_out), 32'(ed));
        last_stall = s;
        if (req && !e && !s && rst_n) begin
            bank_free[b] = cyc + BANK_BUSY;
            if (w) model_mem[k] = d;
            else   exp_q.push_back('{cyc + RD_LAT, model_mem[k]});
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) step(16'h0000, 16'h0000, 1'b0, 1'b0);
    endtask

    task automatic reset_cycles(input int n);
        rst_n = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 4; i++) bank_free[i] = 0;
        idle(n);
        rst_n = 1'b1;
    endtask

    // Requester behaviour: keep the request steady while stalled.
    task automatic hold_until_accept(input logic [15:0] a, input logic [15:0] d,
                                     input logic w, input logic r, output int n_stall);
        n_stall = 0;
        for (int t = 0; t < 20; t++) begin
            step(a, d, w, r);
            if (!last_stall) break;
            n_stall++;
        end
        check("accept_bound", 32'(last_stall), 32'd0);
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rdat;
        logic        rw;
        logic        rr;
        int          op;

        for (int i = 0; i < 4; i++) bank_free[i] = 0;
        rst_n       = 1'b0;
        bus.addr    = 16'h0000;
        bus.data_in = 16'h0000;
        bus.wr      = 1'b0;
        bus.rd      = 1'b0;
        @(posedge clk);
        #1;

        // Reset then idle
        reset_cycles(3);
        idle(2);

        // Line write on consecutive banks: never stalls
        for (int i = 0; i < 4; i++) begin
            step(16'h0010 + 16'(2 * i), 16'hA0A0 + 16'(i), 1'b1, 1'b0);
            check("line_wr_nostall", 32'(last_stall), 32'd0);
        end
        // Line read: bank 0 is free again exactly four cycles after its write
        for (int i = 0; i < 4; i++) begin
            step(16'h0010 + 16'(2 * i), 16'h0000, 1'b0, 1'b1);
            check("line_rd_nostall", 32'(last_stall), 32'd0);
        end
        idle(4);

        // Bank conflict: 0x0020 and 0x0028 both map to bank 0
        step(16'h0028, 16'hC028, 1'b1, 1'b0);
        idle(4);
        step(16'h0020, 16'hC020, 1'b1, 1'b0);
        idle(4);
        step(16'h0020, 16'h0000, 1'b0, 1'b1);
        hold_until_accept(16'h0028, 16'h0000, 1'b0, 1'b1, stalls);
        check("conflict_stalls", 32'(stalls), 32'd3);
        idle(4);

        // Errors: simultaneous wr/rd must not write; odd address must not read
        step(16'h0004, 16'h5A5A, 1'b1, 1'b0);
        idle(4);
        step(16'h0004, 16'hFFFF, 1'b1, 1'b1);
        idle(1);
        step(16'h0004, 16'h0000, 1'b0, 1'b1);
        idle(3);
        step(16'h0005, 16'h0000, 1'b0, 1'b1);
        idle(3);

        // Reset mid-read: in-flight read dropped, storage survives
        step(16'h0040, 16'hBEEF, 1'b1, 1'b0);
        idle(4);
        step(16'h0040, 16'h0000, 1'b0, 1'b1);
        reset_cycles(2);
        idle(1);
        step(16'h0040, 16'h0000, 1'b0, 1'b1);
        idle(3);

        // Read-after-write to the same address
        step(16'h0030, 16'h1234, 1'b1, 1'b0);
        hold_until_accept(16'h0030, 16'h0000, 1'b0, 1'b1, stalls);
        check("raw_stalls", 32'(stalls), 32'd3);
        idle(4);

        // Randomized traffic over a 32-word window, filled first
        for (int i = 0; i < 32; i++) begin
            hold_until_accept(16'h0100 + 16'(2 * i), 16'($urandom), 1'b1, 1'b0, stalls);
        end
        ra = 16'h0000; rdat = 16'h0000; rw = 1'b0; rr = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!(last_stall && $urandom_range(0, 3) != 0)) begin
                ra   = 16'h0100 + 16'(2 * $urandom_range(0, 31));
                if ($urandom_range(0, 15) == 0) ra[0] = 1'b1;
                rdat = 16'($urandom);
                op   = int'($urandom_range(0, 7));
                rr   = (op <= 2) || (op == 5);
                rw   = (op == 3) || (op == 4) || (op == 5);
            end
            step(ra, rdat, rw, rr);
        end
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_banked_mem
